line_ring_buffer: RTL and testbench
===================================

# line_ring_buffer

Parametrised multi-bank scanline buffer, the next generation of the two-bank double buffer between the pixel producer and the VGA scan-out. A producer writes pixels one at a time over a valid/ready handshake. Each completed line is handed to the display side as one packed horizontal raster, together with its line index. The number of banks, line width, frame height and pixel size are all parameters. A frame-sync input and an underrun flag are added.

## Interface
- WIDTH, default `WIDTH (640): pixels per line
- HEIGHT, default `HEIGHT (480): lines per frame; hline_sel wraps at HEIGHT
- PIXEL_SIZE, default `PIXEL_SIZE (8): bits per pixel
- NUM_BANKS, default 2: line banks in the ring, legal range 2..4
- Derived constants: COL_W = log2(WIDTH), LINE_W = log2(HEIGHT)+1, BANK_W = log2(NUM_BANKS)
- clk  in  1  sole clock, rising-edge
- resetn  in  1  asynchronous, active-low reset
- wr_valid  in  1  producer offers wr_pixel
- wr_ready  out  1  block can accept a pixel
- wr_pixel  in  PIXEL_SIZE  pixel data
- wr_sof  in  1  qualified by wr_valid; marks the first pixel of a frame
- rd_valid  out  1  a complete line is presented on packed_buffer
- rd_advance  in  1  single-cycle pulse: display releases the presented line
- packed_buffer  out  WIDTH*PIXEL_SIZE  presented line; pixel j sits at bits [(j+1)*PIXEL_SIZE-1 : j*PIXEL_SIZE]
- hline_sel  out  LINE_W  line index of the presented line
- underrun  out  1  one-cycle pulse when rd_advance arrives while rd_valid=0

## Operation
- State held in the block:
  - NUM_BANKS line banks
  - wr_bank, rd_bank (0..NUM_BANKS-1, wrap)
  - wr_col (0..WIDTH-1)
  - full_cnt (0..NUM_BANKS)
  - wr_line and rd_line (0..HEIGHT-1, wrap)
  - per-bank line tag (LINE_W)
- wr_ready = (full_cnt < NUM_BANKS). It depends only on registered full_cnt. There is no same-cycle bypass from rd_advance.
- Write accept (wr_valid & wr_ready):
  - wr_pixel is stored at bank[wr_bank] column wr_col.
  - If wr_col = WIDTH-1, the line completes. wr_col returns to 0, the tag of wr_bank is set to wr_line, wr_bank advances, wr_line increments (wrapping to 0 after HEIGHT-1), and full_cnt increments.
  - Otherwise wr_col increments.
- wr_sof on an accepted pixel:
  - Any partial line in wr_bank is discarded.
  - The pixel is written at column 0, wr_col becomes 1, and wr_line becomes 0.
  - Lines already completed are unaffected.
- rd_valid = (full_cnt > 0).
- packed_buffer = bank[rd_bank]. hline_sel = tag[rd_bank].
- rd_advance with rd_valid=1: rd_bank advances and full_cnt decrements.
- rd_advance with rd_valid=0: ignored; underrun pulses high.
- Line completion and rd_advance in the same cycle: full_cnt is unchanged and both pointers advance.
- A bank being presented is never written: the full-count rule guarantees wr_bank ≠ rd_bank whenever full_cnt > 0 and a write is accepted.
- Reset (asynchronous, while resetn=0):
  - All pointers, counters and tags clear to 0. Bank storage clears to 0.
  - Outputs: wr_ready=1, rd_valid=0, packed_buffer=0, hline_sel=0, underrun=0.
- Reset mid-line or mid-frame: all content is lost and there is no partial-line recovery.

## Timing
- Pixel write latency is one cycle to storage.
- Last pixel of a line accepted at edge N: rd_valid rises after edge N if full_cnt was 0, and packed_buffer is valid in the same cycle.
- rd_advance sampled at edge M: packed_buffer and hline_sel show the next bank after edge M. If none is ready, rd_valid falls.
- wr_ready falls the cycle after the completion that fills the last free bank. It rises the cycle after the rd_advance that frees one.
- Throughput: one pixel per cycle sustained while the display keeps pace.
- packed_buffer is a combinational mux of bank registers. It is stable from rd_valid until rd_advance is sampled.

## Structure
- Shared include (vga_defs): WIDTH, HEIGHT, PIXEL_SIZE, PACKED_SIZE defaults.
- Shared include: the log2 function, also used by benches.
- Sub-module line_bank:
  - one WIDTH×PIXEL_SIZE register line
  - inputs: clk, resetn, we, col, pixel
  - output: packed line
  - generate-instantiated NUM_BANKS times
- Top level holds the pointers, counters, tags, output mux and underrun logic.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, PIXEL_SIZE=8, NUM_BANKS=2 unless noted.
- Reset: resetn low mid-write, then high -> wr_ready=1, rd_valid=0, packed_buffer=0, hline_sel=0.
- Single line: write 0x11,0x22,0x33,0x44 -> rd_valid=1 one cycle after the last accept; packed_buffer=0x44332211; hline_sel=0.
- Backpressure: write 8 pixels with no rd_advance -> wr_ready=0 after the 8th accept; the 9th pixel is held. Then one rd_advance -> wr_ready=1 next cycle; hline_sel=1.
- Wrap: stream 4 lines, advancing each as it completes -> hline_sel sequence 0,1,2,0.
- Frame sync: write 2 pixels, then wr_sof with 0xAA and 3 more pixels -> presented line begins 0xAA and hline_sel=0; the partial pixels never appear.
- Underrun and simultaneous events: rd_advance with rd_valid=0 -> underrun pulses once and state is unchanged. Completion plus rd_advance in the same cycle with NUM_BANKS=3 -> full_cnt unchanged.

Source files
------------

// File: rtl/line_ring_buffer_pkg.sv
// Shared defaults and helpers for the multi-bank scanline buffer.
// Default geometry matches the VGA timing in use; clog2 is also used by the benches.
package line_ring_buffer_pkg;

  localparam int unsigned DefWidth      = 640;
  localparam int unsigned DefHeight     = 480;
  localparam int unsigned DefPixelSize  = 8;
  localparam int unsigned DefPackedSize = DefWidth * DefPixelSize;

  // Ceiling log2, never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/line_ring_buffer_if.sv
// Producer/display handshake bundle for line_ring_buffer.
// master = pixel producer plus scan-out side, slave = the buffer itself.
interface line_ring_buffer_if
  import line_ring_buffer_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned HEIGHT     = DefHeight,
  parameter int unsigned PIXEL_SIZE = DefPixelSize
) ();

  localparam int unsigned LINE_W = clog2(HEIGHT) + 1;

  logic                          wr_valid;
  logic                          wr_ready;
  logic [PIXEL_SIZE-1:0]         wr_pixel;
  logic                          wr_sof;
  logic                          rd_valid;
  logic                          rd_advance;
  logic [WIDTH*PIXEL_SIZE-1:0]   packed_buffer;
  logic [LINE_W-1:0]             hline_sel;
  logic                          underrun;

  modport master (
    output wr_valid, wr_pixel, wr_sof, rd_advance,
    input  wr_ready, rd_valid, packed_buffer, hline_sel, underrun
  );

  modport slave (
    input  wr_valid, wr_pixel, wr_sof, rd_advance,
    output wr_ready, rd_valid, packed_buffer, hline_sel, underrun
  );

endinterface

// File: rtl/line_bank.sv
// One scanline of pixel registers, written one column at a time and
// exposed as a packed raster (pixel j at bits [(j+1)*PIXEL_SIZE-1 : j*PIXEL_SIZE]).
module line_bank #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PIXEL_SIZE = 8,
  parameter int unsigned COL_W      = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        we_i,
  input  logic [COL_W-1:0]            col_i,
  input  logic [PIXEL_SIZE-1:0]       pixel_i,
  output logic [WIDTH*PIXEL_SIZE-1:0] line_o
);

  logic [PIXEL_SIZE-1:0] pix_q [WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned j = 0; j < WIDTH; j++) pix_q[j] <= '0;
    end else if (we_i) begin
      pix_q[col_i] <= pixel_i;
    end
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_pack
    assign line_o[j*PIXEL_SIZE +: PIXEL_SIZE] = pix_q[j];
  end

endmodule

// File: rtl/line_ring_buffer.sv
// Ring of NUM_BANKS scanline banks between a pixel producer and the scan-out.
// Completed lines are presented in order with their frame line index.
module line_ring_buffer
  import line_ring_buffer_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned HEIGHT     = DefHeight,
  parameter int unsigned PIXEL_SIZE = DefPixelSize,
  parameter int unsigned NUM_BANKS  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  line_ring_buffer_if.slave  bus_io
);

  localparam int unsigned COL_W    = clog2(WIDTH);
  localparam int unsigned LINE_W   = clog2(HEIGHT) + 1;
  localparam int unsigned BANK_W   = clog2(NUM_BANKS);
  localparam int unsigned CNT_W    = clog2(NUM_BANKS + 1);
  localparam int unsigned PACKED_W = WIDTH * PIXEL_SIZE;

  localparam logic [COL_W-1:0]  ColLast  = COL_W'(WIDTH - 1);
  localparam logic [LINE_W-1:0] LineLast = LINE_W'(HEIGHT - 1);
  localparam logic [BANK_W-1:0] BankLast = BANK_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0]  CntFull  = CNT_W'(NUM_BANKS);

  function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
    return (b == BankLast) ? '0 : b + 1'b1;
  endfunction

  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [CNT_W-1:0]  full_cnt_q, full_cnt_d;
  logic [LINE_W-1:0] wr_line_q, wr_line_d;
  logic [LINE_W-1:0] tag_q [NUM_BANKS];
  logic              underrun_q;

  logic                wr_ready, rd_valid, wr_fire, rd_fire, line_done;
  logic [COL_W-1:0]    eff_col;
  logic [LINE_W-1:0]   cur_line;
  logic [NUM_BANKS-1:0] bank_we;
  logic [PACKED_W-1:0] bank_line [NUM_BANKS];

  assign wr_ready  = (full_cnt_q < CntFull);
  assign rd_valid  = (full_cnt_q != '0);
  assign wr_fire   = bus_io.wr_valid & wr_ready;
  assign rd_fire   = bus_io.rd_advance & rd_valid;
  // Start-of-frame restarts the current bank at column 0 and line 0.
  assign eff_col   = bus_io.wr_sof ? '0 : wr_col_q;
  assign cur_line  = bus_io.wr_sof ? '0 : wr_line_q;
  assign line_done = wr_fire & (eff_col == ColLast);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = wr_fire & (wr_bank_q == BANK_W'(b));

    line_bank #(
      .WIDTH      (WIDTH),
      .PIXEL_SIZE (PIXEL_SIZE),
      .COL_W      (COL_W)
    ) u_bank (
      .clk     (clk),
      .resetn  (resetn),
      .we_i    (bank_we[b]),
      .col_i   (eff_col),
      .pixel_i (bus_io.wr_pixel),
      .line_o  (bank_line[b])
    );
  end

  always_comb begin
    wr_col_d  = wr_col_q;
    wr_line_d = wr_line_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire) begin
      if (line_done) begin
        wr_col_d  = '0;
        wr_bank_d = bank_inc(wr_bank_q);
        wr_line_d = (cur_line == LineLast) ? '0 : cur_line + 1'b1;
      end else begin
        wr_col_d  = eff_col + 1'b1;
        wr_line_d = cur_line;
      end
    end
  end

  always_comb begin
    rd_bank_d  = rd_fire ? bank_inc(rd_bank_q) : rd_bank_q;
    full_cnt_d = full_cnt_q;
    unique case ({line_done, rd_fire})
      2'b10:   full_cnt_d = full_cnt_q + 1'b1;
      2'b01:   full_cnt_d = full_cnt_q - 1'b1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      wr_col_q   <= '0;
      full_cnt_q <= '0;
      wr_line_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_col_q   <= wr_col_d;
      full_cnt_q <= full_cnt_d;
      wr_line_q  <= wr_line_d;
      underrun_q <= bus_io.rd_advance & ~rd_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) tag_q[b] <= '0;
    end else if (line_done) begin
      tag_q[wr_bank_q] <= cur_line;
    end
  end

  assign bus_io.wr_ready      = wr_ready;
  assign bus_io.rd_valid      = rd_valid;
  assign bus_io.packed_buffer = bank_line[rd_bank_q];
  assign bus_io.hline_sel     = tag_q[rd_bank_q];
  assign bus_io.underrun      = underrun_q;

endmodule

// File: tb/tb_line_ring_buffer.sv
// Directed bench for line_ring_buffer: WIDTH=4, HEIGHT=3, PIXEL_SIZE=8,
// one instance with two banks and one with three for the simultaneous-event case.
module tb_line_ring_buffer;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned PS = 8;

  logic clk;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  line_ring_buffer_if #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS)) bus2 ();
  line_ring_buffer_if #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS)) bus3 ();

  line_ring_buffer #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS), .NUM_BANKS(2)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus_io (bus2)
  );

  line_ring_buffer #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS), .NUM_BANKS(3)) dut3 (
    .clk    (clk),
    .resetn (resetn),
    .bus_io (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic push2(input logic [7:0] pix, input logic sof);
    bus2.wr_valid = 1'b1;
    bus2.wr_pixel = pix;
    bus2.wr_sof   = sof;
    tick();
    bus2.wr_valid = 1'b0;
    bus2.wr_sof   = 1'b0;
  endtask

  task automatic push3(input logic [7:0] pix);
    bus3.wr_valid = 1'b1;
    bus3.wr_pixel = pix;
    tick();
    bus3.wr_valid = 1'b0;
  endtask

  task automatic advance2();
    bus2.rd_advance = 1'b1;
    tick();
    bus2.rd_advance = 1'b0;
  endtask

  logic [31:0] exp_line;
  logic [2:0]  exp_tag [4];

  initial begin
    resetn          = 1'b0;
    bus2.wr_valid   = 1'b0;
    bus2.wr_pixel   = '0;
    bus2.wr_sof     = 1'b0;
    bus2.rd_advance = 1'b0;
    bus3.wr_valid   = 1'b0;
    bus3.wr_pixel   = '0;
    bus3.wr_sof     = 1'b0;
    bus3.rd_advance = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Reset asserted in the middle of a line, with the producer still offering.
    push2(8'h55, 1'b0);
    bus2.wr_valid = 1'b1;
    bus2.wr_pixel = 8'h66;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async_wr_ready", 64'(bus2.wr_ready), 64'd1);
    chk("rst_async_rd_valid", 64'(bus2.rd_valid), 64'd0);
    bus2.wr_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    chk("rst_wr_ready", 64'(bus2.wr_ready), 64'd1);
    chk("rst_rd_valid", 64'(bus2.rd_valid), 64'd0);
    chk("rst_packed", 64'(bus2.packed_buffer), 64'd0);
    chk("rst_hline", 64'(bus2.hline_sel), 64'd0);
    chk("rst_underrun", 64'(bus2.underrun), 64'd0);

    // Single line.
    push2(8'h11, 1'b0);
    push2(8'h22, 1'b0);
    push2(8'h33, 1'b0);
    chk("single_not_yet_valid", 64'(bus2.rd_valid), 64'd0);
    push2(8'h44, 1'b0);
    chk("single_rd_valid", 64'(bus2.rd_valid), 64'd1);
    chk("single_packed", 64'(bus2.packed_buffer), 64'h44332211);
    chk("single_hline", 64'(bus2.hline_sel), 64'd0);
    chk("single_wr_ready", 64'(bus2.wr_ready), 64'd1);
    advance2();
    chk("single_adv_rd_valid", 64'(bus2.rd_valid), 64'd0);
    chk("single_adv_no_underrun", 64'(bus2.underrun), 64'd0);

    // Backpressure: two lines fill both banks.
    do_reset();
    for (int i = 1; i <= 8; i++) push2(8'(i), 1'b0);
    chk("bp_wr_ready_low", 64'(bus2.wr_ready), 64'd0);
    chk("bp_packed_first", 64'(bus2.packed_buffer), 64'h04030201);
    chk("bp_hline_first", 64'(bus2.hline_sel), 64'd0);
    bus2.wr_valid = 1'b1;
    bus2.wr_pixel = 8'h09;
    tick();
    tick();
    chk("bp_held_wr_ready", 64'(bus2.wr_ready), 64'd0);
    chk("bp_held_packed", 64'(bus2.packed_buffer), 64'h04030201);
    bus2.rd_advance = 1'b1;
    tick();
    bus2.rd_advance = 1'b0;
    chk("bp_release_wr_ready", 64'(bus2.wr_ready), 64'd1);
    chk("bp_release_hline", 64'(bus2.hline_sel), 64'd1);
    chk("bp_release_packed", 64'(bus2.packed_buffer), 64'h08070605);
    tick();
    bus2.wr_valid = 1'b0;
    chk("bp_presented_stable", 64'(bus2.packed_buffer), 64'h08070605);

    // Line index wraps at HEIGHT.
    do_reset();
    exp_tag[0] = 3'd0;
    exp_tag[1] = 3'd1;
    exp_tag[2] = 3'd2;
    exp_tag[3] = 3'd0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_line[j*8 +: 8] = 8'(16 * (k + 1) + j);
        push2(8'(16 * (k + 1) + j), 1'b0);
      end
      chk($sformatf("wrap_hline_%0d", k), 64'(bus2.hline_sel), 64'(exp_tag[k]));
      chk($sformatf("wrap_packed_%0d", k), 64'(bus2.packed_buffer), 64'(exp_line));
      advance2();
    end

    // Frame sync discards the partial line and restarts line numbering.
    push2(8'hE1, 1'b0);
    push2(8'hE2, 1'b0);
    push2(8'hAA, 1'b1);
    push2(8'hBB, 1'b0);
    push2(8'hCC, 1'b0);
    chk("sof_not_yet_valid", 64'(bus2.rd_valid), 64'd0);
    push2(8'hDD, 1'b0);
    chk("sof_rd_valid", 64'(bus2.rd_valid), 64'd1);
    chk("sof_packed", 64'(bus2.packed_buffer), 64'hDDCCBBAA);
    chk("sof_hline", 64'(bus2.hline_sel), 64'd0);
    advance2();

    // Underrun: advance with nothing presented.
    advance2();
    chk("ur_pulse", 64'(bus2.underrun), 64'd1);
    chk("ur_rd_valid", 64'(bus2.rd_valid), 64'd0);
    chk("ur_wr_ready", 64'(bus2.wr_ready), 64'd1);
    tick();
    chk("ur_pulse_ends", 64'(bus2.underrun), 64'd0);
    for (int i = 1; i <= 4; i++) push2(8'(i), 1'b0);
    chk("ur_after_rd_valid", 64'(bus2.rd_valid), 64'd1);
    chk("ur_after_hline", 64'(bus2.hline_sel), 64'd1);
    chk("ur_after_packed", 64'(bus2.packed_buffer), 64'h04030201);

    // Three banks: completion and advance on the same edge.
    push3(8'h21);
    push3(8'h22);
    push3(8'h23);
    push3(8'h24);
    chk("nb3_first_hline", 64'(bus3.hline_sel), 64'd0);
    chk("nb3_first_packed", 64'(bus3.packed_buffer), 64'h24232221);
    push3(8'h31);
    push3(8'h32);
    push3(8'h33);
    bus3.rd_advance = 1'b1;
    push3(8'h34);
    bus3.rd_advance = 1'b0;
    chk("nb3_full_cnt", 64'(dut3.full_cnt_q), 64'd1);
    chk("nb3_rd_valid", 64'(bus3.rd_valid), 64'd1);
    chk("nb3_hline", 64'(bus3.hline_sel), 64'd1);
    chk("nb3_packed", 64'(bus3.packed_buffer), 64'h34333231);
    chk("nb3_wr_ready", 64'(bus3.wr_ready), 64'd1);
    chk("nb3_no_underrun", 64'(bus3.underrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
